// File: rtl/scan_sequencer.sv
// scan_sequencer: drives the select index and enable of a 3-to-8 one-hot
// decoder. Each index is held for DIV clocks ("dwell").
//
// Parameters
//   DIV  : dwell length in clocks per index value (1..255)
//   LAST : highest index value (1..7)
//
// Ports
//   clk   in   system clock, rising edge
//   rst_n in   asynchronous active-low reset
//   start in   one-cycle request to begin/restart a sweep
//   stop  in   one-cycle abort request, wins over start
//   dir   in   0 = up, 1 = down (sampled on accepted start)
//   mode  in   0 = continuous wrap, 1 = single sweep (sampled on accepted start)
//   sel   out  current index to the decoder
//   en    out  decoder enable, high while running
//   tick  out  high on the first clock of every dwell
//   done  out  one-cycle pulse when a single sweep completes
module scan_sequencer #(
  parameter int DIV  = 4,
  parameter int LAST = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       dir,
  input  logic       mode,
  output logic [2:0] sel,
  output logic       en,
  output logic       tick,
  output logic       done
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [7:0] PC_END   = 8'(DIV - 1);
  localparam logic [2:0] SEL_LAST = 3'(LAST);

  state_t     state, state_n;
  logic [7:0] pc, pc_n;
  logic       dir_q, dir_n;
  logic       mode_q, mode_n;
  logic [2:0] sel_n;
  logic       en_n, tick_n, done_n;

  // Index reached at the end of a sweep in the latched direction.
  logic at_final;
  assign at_final = dir_q ? (sel == 3'd0) : (sel == SEL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pc     <= '0;
      dir_q  <= 1'b0;
      mode_q <= 1'b0;
      sel    <= '0;
      en     <= 1'b0;
      tick   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      pc     <= pc_n;
      dir_q  <= dir_n;
      mode_q <= mode_n;
      sel    <= sel_n;
      en     <= en_n;
      tick   <= tick_n;
      done   <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc;
    dir_n   = dir_q;
    mode_n  = mode_q;
    sel_n   = sel;
    en_n    = en;
    tick_n  = 1'b0;
    done_n  = 1'b0;

    unique case (state)
      IDLE: begin
        en_n = 1'b0;
        if (start && !stop) begin
          state_n = RUN;
          dir_n   = dir;
          mode_n  = mode;
          sel_n   = dir ? SEL_LAST : 3'd0;
          pc_n    = '0;
          en_n    = 1'b1;
          tick_n  = 1'b1;
        end
      end
      RUN: begin
        if (stop) begin
          // Abort beats any advance or sweep end on this edge; sel holds.
          state_n = IDLE;
          en_n    = 1'b0;
          pc_n    = '0;
        end else if (start) begin
          // Restart beats a coincident sweep end, so no done pulse.
          dir_n  = dir;
          mode_n = mode;
          sel_n  = dir ? SEL_LAST : 3'd0;
          pc_n   = '0;
          en_n   = 1'b1;
          tick_n = 1'b1;
        end else if (pc == PC_END) begin
          pc_n = '0;
          if (mode_q && at_final) begin
            state_n = IDLE;
            en_n    = 1'b0;
            done_n  = 1'b1;
          end else begin
            tick_n = 1'b1;
            if (!dir_q) sel_n = (sel == SEL_LAST) ? 3'd0 : sel + 3'd1;
            else        sel_n = (sel == 3'd0) ? SEL_LAST : sel - 3'd1;
          end
        end else begin
          pc_n = pc + 8'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Scoreboard bench for scan_sequencer. Two instances: A (DIV=4, LAST=7) and
// B (DIV=2, LAST=5). Stimulus pushes hand-computed expected outputs right
// after each rising edge; the monitor pops and compares on the falling edge.
module tb_scan_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic start_a, stop_a, dir_a, mode_a;
  logic start_b, stop_b, dir_b, mode_b;
  logic [2:0] sel_a, sel_b;
  logic en_a, tick_a, done_a, en_b, tick_b, done_b;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit         b;
    string      nm;
    logic [2:0] sel;
    logic       en;
    logic       tick;
    logic       done;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  scan_sequencer #(.DIV(4), .LAST(7)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a), .dir(dir_a),
    .mode(mode_a), .sel(sel_a), .en(en_a), .tick(tick_a), .done(done_a));

  scan_sequencer #(.DIV(2), .LAST(5)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stop(stop_b), .dir(dir_b),
    .mode(mode_b), .sel(sel_b), .en(en_b), .tick(tick_b), .done(done_b));

  // Monitor: compares every pending expectation against the chosen DUT.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      logic [5:0] act, ex;
      e   = q.pop_front();
      act = e.b ? {sel_b, en_b, tick_b, done_b} : {sel_a, en_a, tick_a, done_a};
      ex  = {e.sel, e.en, e.tick, e.done};
      n_chk++;
      if (act !== ex) begin
        n_fail++;
        $display("FAIL %s (%s): got sel=%0d en=%b tick=%b done=%b, expected sel=%0d en=%b tick=%b done=%b",
                 e.nm, e.b ? "B" : "A", act[5:3], act[2], act[1], act[0],
                 ex[5:3], ex[2], ex[1], ex[0]);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit b, input string nm, input logic [2:0] s,
                      input logic e, input logic t, input logic d);
    exp_t x;
    x.b = b; x.nm = nm; x.sel = s; x.en = e; x.tick = t; x.done = d;
    q.push_back(x);
  endtask

  initial begin
    start_a = 0; stop_a = 0; dir_a = 0; mode_a = 0;
    start_b = 0; stop_b = 0; dir_b = 0; mode_b = 0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset held 3 cycles, then 10 idle cycles with no start.
    repeat (3) begin
      cyc();
      push(0, "reset", 3'd0, 0, 0, 0);
      push(1, "reset", 3'd0, 0, 0, 0);
    end
    rst_n = 1'b1;
    repeat (10) begin
      cyc();
      push(0, "idle", 3'd0, 0, 0, 0);
      push(1, "idle", 3'd0, 0, 0, 0);
    end

    // A: up, single sweep. Index k-1 of the sweep is cycle k after start.
    start_a = 1; dir_a = 0; mode_a = 1;
    cyc();
    start_a = 0;
    for (int k = 1; k <= 34; k++) begin
      if (k <= 32)      push(0, "up_single", 3'((k - 1) / 4), 1, ((k - 1) % 4) == 0, 0);
      else if (k == 33) push(0, "up_single_done", 3'd7, 0, 0, 1);
      else              push(0, "up_single_after", 3'd7, 0, 0, 0);
      cyc();
    end

    // B: down, continuous, wraps 0 -> 5. Stop lands on an advance edge.
    start_b = 1; dir_b = 1; mode_b = 0;
    cyc();
    start_b = 0;
    for (int k = 1; k <= 36; k++) begin
      push(1, "down_wrap", 3'(5 - (((k - 1) / 2) % 6)), 1, ((k - 1) % 2) == 0, 0);
      if (k == 36) stop_b = 1;
      cyc();
    end
    stop_b = 0;
    push(1, "stop_on_advance", 3'd0, 0, 0, 0);

    // A: stop on the second clock of sel=3, then restart reloads 0.
    start_a = 1; dir_a = 0; mode_a = 0;
    cyc();
    start_a = 0;
    for (int k = 1; k <= 14; k++) begin
      push(0, "pre_stop", 3'((k - 1) / 4), 1, ((k - 1) % 4) == 0, 0);
      if (k == 14) stop_a = 1;
      cyc();
    end
    stop_a = 0;
    push(0, "stop_mid_dwell", 3'd3, 0, 0, 0);
    cyc();
    push(0, "stop_hold", 3'd3, 0, 0, 0);
    start_a = 1;
    cyc();
    start_a = 0;
    push(0, "restart_reload", 3'd0, 1, 1, 0);
    stop_a = 1;
    cyc();
    stop_a = 0;
    push(0, "stop_again", 3'd0, 0, 0, 0);

    // A: start and stop together in IDLE stays idle.
    start_a = 1; stop_a = 1;
    cyc();
    start_a = 0; stop_a = 0;
    push(0, "start_stop_idle", 3'd0, 0, 0, 0);

    // A: restart at sel=6 with dir=1 reloads LAST and counts down.
    start_a = 1; dir_a = 0; mode_a = 0;
    cyc();
    start_a = 0;
    for (int k = 1; k <= 25; k++) begin
      push(0, "pre_restart", 3'((k - 1) / 4), 1, ((k - 1) % 4) == 0, 0);
      if (k == 25) begin start_a = 1; dir_a = 1; mode_a = 1; end
      cyc();
    end
    start_a = 0;
    push(0, "restart_down", 3'd7, 1, 1, 0);
    for (int j = 2; j <= 5; j++) begin
      cyc();
      if (j == 5) push(0, "restart_down_step", 3'd6, 1, 1, 0);
      else        push(0, "restart_down_hold", 3'd7, 1, 0, 0);
    end
    stop_a = 1;
    cyc();
    stop_a = 0;
    push(0, "stop_after_restart", 3'd6, 0, 0, 0);

    // B: start coincident with single-sweep end -> no done, en stays high.
    start_b = 1; dir_b = 0; mode_b = 1;
    cyc();
    start_b = 0;
    for (int k = 1; k <= 12; k++) begin
      push(1, "up_single_b", 3'((k - 1) / 2), 1, ((k - 1) % 2) == 0, 0);
      if (k == 12) begin start_b = 1; dir_b = 0; mode_b = 0; end
      cyc();
    end
    start_b = 0;
    push(1, "restart_at_end", 3'd0, 1, 1, 0);
    cyc();
    push(1, "restart_at_end_next", 3'd0, 1, 0, 0);
    stop_b = 1;
    cyc();
    stop_b = 0;
    push(1, "stop_b", 3'd0, 0, 0, 0);

    // B: down single sweep ends at 0 with done.
    start_b = 1; dir_b = 1; mode_b = 1;
    cyc();
    start_b = 0;
    for (int k = 1; k <= 14; k++) begin
      if (k <= 12)      push(1, "down_single", 3'(5 - (k - 1) / 2), 1, ((k - 1) % 2) == 0, 0);
      else if (k == 13) push(1, "down_single_done", 3'd0, 0, 0, 1);
      else              push(1, "down_single_after", 3'd0, 0, 0, 0);
      cyc();
    end

    // A: async reset between edges while sel=4.
    start_a = 1; dir_a = 0; mode_a = 1;
    cyc();
    start_a = 0;
    for (int k = 1; k <= 17; k++) begin
      push(0, "pre_async_rst", 3'((k - 1) / 4), 1, ((k - 1) % 4) == 0, 0);
      cyc();
    end
    #2 rst_n = 1'b0;
    push(0, "async_rst", 3'd0, 0, 0, 0);
    cyc();
    push(0, "rst_hold", 3'd0, 0, 0, 0);
    rst_n = 1'b1;
    repeat (3) begin
      cyc();
      push(0, "no_done_after_rst", 3'd0, 0, 0, 0);
    end

    @(negedge clk);
    #1;
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
- Upstream driver for the 3-to-8 one-hot decoder stage. Generates the 3-bit select index `sel` and the enable `en` that the decoder turns into a one-hot output.
- Steps the index through 0..LAST, spending a programmable number of clocks (a "dwell") on each value.
- Supports up/down direction and continuous or single-sweep operation.
- Used to scan LEDs or display digits one at a time.

Parameters:
- DIV, 4: dwell length in clocks per index value; legal range 1..255.
- LAST, 7: highest index value; legal range 1..7.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle request to begin or restart a sweep.
- stop  input  1  one-cycle request to abort; takes priority over start.
- dir  input  1  0 = count up, 1 = count down; sampled only on an accepted start.
- mode  input  1  0 = continuous wrap, 1 = single sweep; sampled only on an accepted start.
- sel  output  3  current index, wired to the decoder's `in`.
- en  output  1  decoder enable; high while RUN.
- tick  output  1  high for the first clock of every dwell.
- done  output  1  one-cycle pulse when a single sweep completes.

Behaviour:
- Reset (rst_n = 0, asynchronous):
  - state goes to IDLE.
  - sel = 0, en = 0, tick = 0, done = 0.
  - Prescaler count pc = 0; the latched dir and mode copies are cleared.
- Reset asserted mid-sweep aborts immediately; done is not pulsed.
- All outputs are registered.
- FSM states: IDLE and RUN.
- IDLE:
  - en = 0; sel holds its last value.
  - start = 1 and stop = 0 at an edge:
    - enter RUN and latch dir and mode.
    - sel is loaded with 0 when up, LAST when down.
    - pc = 0, en = 1, tick = 1.
  - The first index is therefore visible one clock after start.
- RUN, prescaler:
  - pc increments each clock.
  - At an edge where pc == DIV-1: pc becomes 0, sel advances one step, tick = 1 for the next clock.
  - tick = 0 on all other clocks.
  - Each index is therefore held for exactly DIV clocks, and tick marks the first of them.
  - DIV = 1: sel advances every clock and tick stays high continuously.
- RUN, advance rule when going up:
  - sel == LAST wraps to 0.
  - Otherwise sel + 1.
- RUN, advance rule when going down:
  - sel == 0 wraps to LAST.
  - Otherwise sel - 1.
- Single-sweep end (mode = 1):
  - Triggered at the advance edge from the final index: LAST when up, 0 when down.
  - Do not wrap; go to IDLE.
  - en = 0, done = 1 for one clock, tick = 0.
  - sel holds the final index.
- stop in RUN:
  - Next edge goes to IDLE: en = 0, tick = 0, pc = 0, done = 0.
  - sel holds its current value.
  - This applies even if the same edge would have been an advance or the sweep end.
- stop in IDLE is ignored.
- start in RUN (without stop):
  - Restart: reload sel for the newly sampled dir, pc = 0, tick = 1.
  - The new mode is latched; en stays 1.
  - No done pulse.
- start arriving on the same edge as the sweep end: the restart wins and done = 0.
- The decoder output is never active while en = 0; the sequencer guarantees that sel only changes while en = 1 or on a start edge.

Test Plan:
- Reset then idle, with rst_n held low for 3 cycles → sel=0, en=0, tick=0, done=0. After release, with no start for 10 cycles, all outputs are unchanged.
- DIV=4, LAST=7, dir=0, mode=1, start pulse at cycle 0:
  - en=1 from cycle 1; sel = 0,1,…,7, each value held 4 clocks; tick high at cycles 1,5,…,29.
  - At cycle 33: en=0, done=1 for one cycle, sel=7.
- DIV=2, LAST=5, dir=1, mode=0:
  - sel sequence is 5,4,3,2,1,0,5,4,…, 2 clocks each.
  - Wrap from 0 to 5 with no done pulse; runs for ≥30 cycles.
- Stop mid-dwell, with DIV=4 and stop at the second clock of sel=3 → next clock en=0, sel=3, tick=0, done=0. A later start reloads sel=0.
- Simultaneous and restart cases:
  - start and stop on the same edge in IDLE → stays IDLE.
  - start in RUN at sel=6 with dir=1 → next clock sel=LAST and tick=1.
  - start coincident with the single-sweep end → done=0, en stays 1.
- Asynchronous reset mid-sweep, with rst_n dropped between edges at sel=4 → en and sel go to 0 immediately, before the next clk edge; no done pulse.
